// File: rtl/act_grad_pipe_if.sv
// Handshake and data bundle between an upstream producer, the
// activation-gradient pipeline and its downstream consumer.
interface act_grad_pipe_if;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic signed [31:0] in_x;
  logic signed [31:0] in_grad;
  logic signed [31:0] leak_a;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_grad;
  logic               sat_flag;
  logic [15:0]        out_count;

  modport master (
    output in_valid, in_mode, in_x, in_grad, leak_a, out_ready,
    input  in_ready, out_valid, out_grad, sat_flag, out_count
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_grad, leak_a, out_ready,
    output in_ready, out_valid, out_grad, sat_flag, out_count
  );
endinterface

// File: rtl/act_grad_pipe.sv
// Two-stage backward pass of leaky-ReLU / piecewise sigmoid / piecewise tanh:
// S1 classifies x into a shift code, S2 applies it to the upstream gradient.
module act_grad_pipe #(
  parameter int FRAC = 16
) (
  input logic            clk,
  input logic            rst_n,
  act_grad_pipe_if.slave bus
);
  typedef enum logic [1:0] {
    OP_SHIFT = 2'd0,
    OP_ZERO  = 2'd1,
    OP_LEAK  = 2'd2
  } op_e;

  localparam logic [32:0] ONE_C   = 33'd1 << FRAC;
  localparam logic [32:0] HALF_C  = ONE_C >> 1;
  localparam logic [32:0] TWO_C   = ONE_C << 1;
  localparam logic [32:0] THREE_C = ONE_C * 33'd3;
  localparam logic [32:0] FOUR_C  = ONE_C << 2;

  // Clamp a wide signed value to 32 bits; MSB of the result flags a clamp.
  function automatic logic [32:0] sat_narrow(input logic signed [63:0] v);
    logic [32:0] r;
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      r = {1'b1, 32'h7FFF_FFFF};
    end else if (v < 64'shFFFF_FFFF_8000_0000) begin
      r = {1'b1, 32'h8000_0000};
    end else begin
      r = {1'b0, v[31:0]};
    end
    return r;
  endfunction

  logic [1:0]         rst_sync_r;
  logic               run_s;
  logic               s1_valid_r;
  logic signed [31:0] s1_grad_r;
  logic signed [31:0] s1_leak_r;
  op_e                s1_op_r;
  logic [2:0]         s1_sh_r;
  logic               s2_valid_r;
  logic signed [31:0] out_grad_r;
  logic               sat_flag_r;
  logic [15:0]        count_r;

  logic               s1_adv_s;
  logic               s2_adv_s;
  logic               accept_s;
  logic [32:0]        x_ext_s;
  logic [32:0]        abs_x_s;
  op_e                op_s;
  logic [2:0]         sh_s;
  logic signed [63:0] prod_s;
  logic signed [63:0] leak_sh_s;
  logic [32:0]        leak_sat_s;
  logic signed [31:0] res_s;
  logic               res_sat_s;

  // Release synchroniser: stages stay idle until two clean edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign run_s        = rst_sync_r[1];
  assign s2_adv_s     = !s2_valid_r || bus.out_ready;
  assign s1_adv_s     = !s1_valid_r || s2_adv_s;
  assign accept_s     = bus.in_valid && run_s && s1_adv_s;
  assign bus.in_ready = !rst_n || (run_s && s1_adv_s);

  // Segment selection; |x| is 33 bits wide so -2^31 stays in the top segment.
  always_comb begin
    x_ext_s = {bus.in_x[31], bus.in_x};
    abs_x_s = bus.in_x[31] ? (33'd0 - x_ext_s) : x_ext_s;
    op_s    = OP_SHIFT;
    sh_s    = 3'd0;
    case (bus.in_mode)
      2'd0: begin
        if (bus.in_x > 32'sd0) op_s = OP_SHIFT;
        else                   op_s = OP_LEAK;
      end
      2'd1: begin
        if (abs_x_s < ONE_C)       sh_s = 3'd2;
        else if (abs_x_s < TWO_C)  sh_s = 3'd3;
        else if (abs_x_s < FOUR_C) sh_s = 3'd5;
        else                       op_s = OP_ZERO;
      end
      2'd2: begin
        if (abs_x_s < HALF_C)       sh_s = 3'd0;
        else if (abs_x_s < ONE_C)   sh_s = 3'd1;
        else if (abs_x_s < TWO_C)   sh_s = 3'd2;
        else if (abs_x_s < THREE_C) sh_s = 3'd4;
        else                        op_s = OP_ZERO;
      end
      2'd3:    op_s = OP_SHIFT;
      default: op_s = OP_SHIFT;
    endcase
  end

  // S1: operand and segment-code register, held while S2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_grad_r  <= 32'sd0;
      s1_leak_r  <= 32'sd0;
      s1_op_r    <= OP_SHIFT;
      s1_sh_r    <= 3'd0;
    end else if (run_s && s1_adv_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_grad_r <= bus.in_grad;
        s1_leak_r <= bus.leak_a;
        s1_op_r   <= op_s;
        s1_sh_r   <= sh_s;
      end
    end
  end

  // Result datapath for the sample sitting in S1.
  always_comb begin
    prod_s     = 64'(s1_leak_r) * 64'(s1_grad_r);
    leak_sh_s  = prod_s >>> FRAC;
    leak_sat_s = sat_narrow(leak_sh_s);
    res_s      = 32'sd0;
    res_sat_s  = 1'b0;
    case (s1_op_r)
      OP_SHIFT: res_s = s1_grad_r >>> s1_sh_r;
      OP_ZERO:  res_s = 32'sd0;
      OP_LEAK: begin
        res_s     = leak_sat_s[31:0];
        res_sat_s = leak_sat_s[32];
      end
      default:  res_s = 32'sd0;
    endcase
  end

  // S2: output register, sticky saturation flag and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      out_grad_r <= 32'sd0;
      sat_flag_r <= 1'b0;
      count_r    <= 16'd0;
    end else if (run_s) begin
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          out_grad_r <= res_s;
          if (res_sat_s) sat_flag_r <= 1'b1;
        end
      end
      if (s2_valid_r && bus.out_ready) count_r <= count_r + 16'd1;
    end
  end

  assign bus.out_valid = s2_valid_r;
  assign bus.out_grad  = out_grad_r;
  assign bus.sat_flag  = sat_flag_r;
  assign bus.out_count = count_r;
endmodule

// File: tb/tb_act_grad_pipe.sv
// Directed bench for act_grad_pipe: a floor-division reference model feeds a
// per-cycle output checker, plus hand-computed literal vectors.
module tb_act_grad_pipe;
  localparam int     FRAC = 16;
  localparam longint ONE  = 64'sd1 <<< FRAC;

  localparam logic [1:0]  ST_M [10] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2};
  localparam logic [31:0] ST_X [10] = '{32'h0001_0000, 32'hFFFE_0000, 32'h0004_0000, 32'h0000_8000,
                                        32'h8000_0000, 32'h0000_7FFF, 32'h0000_0001, 32'hFFFF_0000,
                                        32'h8000_0000, 32'h0002_0000};
  localparam logic [31:0] ST_G [10] = '{32'h0001_0000, 32'hFFFF_FFFB, 32'h0001_0000, 32'hFFFF_FFFD,
                                        32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000,
                                        32'h0BAD_F00D, 32'h0001_0000};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_popped = 0;
  logic [32:0] exp_q [$];
  logic [15:0] exp_count = 16'd0;
  logic        exp_sat   = 1'b0;

  act_grad_pipe_if bus ();

  act_grad_pipe #(.FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 64'sd0 && a < 64'sd0) q = q - 64'sd1;
    return q;
  endfunction

  // Reference: {saturated, dL/dx} from the slope tables, floor division for shifts.
  function automatic logic [32:0] model(input logic [1:0] m, input int x, input int g, input int a);
    longint ax;
    longint r;
    logic   s;
    ax = (x < 0) ? -longint'(x) : longint'(x);
    r  = longint'(g);
    s  = 1'b0;
    case (m)
      2'd0: begin
        if (x <= 0) begin
          r = fdiv(longint'(a) * longint'(g), ONE);
          if (r > 64'sd2147483647) begin
            r = 64'sd2147483647; s = 1'b1;
          end else if (r < -64'sd2147483648) begin
            r = -64'sd2147483648; s = 1'b1;
          end
        end
      end
      2'd1: begin
        if (ax < ONE)                r = fdiv(longint'(g), 64'sd4);
        else if (ax < 64'sd2 * ONE)  r = fdiv(longint'(g), 64'sd8);
        else if (ax < 64'sd4 * ONE)  r = fdiv(longint'(g), 64'sd32);
        else                         r = 64'sd0;
      end
      2'd2: begin
        if (2 * ax < ONE)            r = longint'(g);
        else if (ax < ONE)           r = fdiv(longint'(g), 64'sd2);
        else if (ax < 64'sd2 * ONE)  r = fdiv(longint'(g), 64'sd4);
        else if (ax < 64'sd3 * ONE)  r = fdiv(longint'(g), 64'sd16);
        else                         r = 64'sd0;
      end
      default: r = longint'(g);
    endcase
    return {s, r[31:0]};
  endfunction

  // Output checker: compares every meaningful cycle against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_count = 16'd0;
      exp_sat   = 1'b0;
      n_popped  = 0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_count", 64'(bus.out_count), 64'd0);
      chk("rst_sat_flag",  64'(bus.sat_flag),  64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    end else begin
      chk("out_count", 64'(bus.out_count), 64'(exp_count));
      if (bus.out_valid) begin
        chk("stale_result", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_sat = exp_sat | exp_q[0][32];
          chk("out_grad", {32'd0, bus.out_grad}, {32'd0, exp_q[0][31:0]});
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 16'd1;
            n_popped++;
          end
        end
      end
      chk("sat_flag", 64'(bus.sat_flag), 64'(exp_sat));
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_mode, bus.in_x, bus.in_grad, bus.leak_a));
    end
  end

  task automatic present(input logic [1:0] m, input logic [31:0] x, input logic [31:0] g,
                         input logic [31:0] a);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_x     = x;
    bus.in_grad  = g;
    bus.leak_a   = a;
  endtask

  // Returns #1 after the edge that accepted the presented sample.
  task automatic wait_accept(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_accept"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic lit_test(input string nm, input logic [1:0] m, input logic [31:0] x,
                          input logic [31:0] g, input logic [31:0] a, input logic [31:0] expv);
    bus.out_ready = 1'b1;
    present(m, x, g, a);
    wait_accept(nm);
    bus.in_valid = 1'b0;
    chk({nm, "_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk(nm, {32'd0, bus.out_grad}, {32'd0, expv});
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.in_x      = 32'sd0;
    bus.in_grad   = 32'sd0;
    bus.leak_a    = 32'sd0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("init_in_ready",  64'(bus.in_ready),  64'd1);
    chk("init_out_valid", 64'(bus.out_valid), 64'd0);
    chk("init_out_grad",  {32'd0, bus.out_grad}, 64'd0);
    chk("init_sat_flag",  64'(bus.sat_flag),  64'd0);
    chk("init_out_count", 64'(bus.out_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the reference model to hand-derived values.
    chk("model_sig_1p0",   64'(model(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0)), 64'h0_0000_2000);
    chk("model_sig_floor", 64'(model(2'd1, 32'hFFFE_0000, 32'hFFFF_FFFB, 32'h0)), 64'h0_FFFF_FFFF);
    chk("model_tanh_min",  64'(model(2'd2, 32'h8000_0000, 32'h1234_5678, 32'h0)), 64'h0_0000_0000);
    chk("model_leak_low",  64'(model(2'd0, 32'hFFFF_0000, 32'h8000_0000, 32'h0003_0000)), 64'h1_8000_0000);

    lit_test("sig_0p5",   2'd1, 32'h0000_8000, 32'h0001_0000, 32'h0000_0000, 32'h0000_4000);
    lit_test("tanh_m1p5", 2'd2, 32'hFFFE_8000, 32'h0004_0000, 32'h0000_0000, 32'h0001_0000);
    lit_test("tanh_3p0",  2'd2, 32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0000_0000);
    lit_test("leaky_sat", 2'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0003_0000, 32'h7FFF_FFFF);
    chk("leaky_sat_flag", 64'(bus.sat_flag), 64'd1);
    lit_test("leaky_x0",  2'd0, 32'h0000_0000, 32'h0001_0000, 32'h0000_1999, 32'h0000_1999);

    // Ten back-to-back samples with a randomly stalling consumer.
    do_reset();
    bus.out_ready = 1'b1;
    begin
      int   i   = 0;
      int   cyc = 0;
      logic acc;
      present(ST_M[0], ST_X[0], ST_G[0], 32'h0000_1999);
      while (i < 10 && cyc < 400) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        if (acc) begin
          i++;
          if (i < 10) present(ST_M[i], ST_X[i], ST_G[i], (i == 7) ? 32'h0003_0000 : 32'h0000_1999);
          else        bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'($urandom_range(0, 1));
        cyc++;
      end
      chk("stream_accepted", 64'(i), 64'd10);
      bus.out_ready = 1'b1;
      cyc = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("stream_results",   64'(n_popped),      64'd10);
      chk("stream_out_count", 64'(bus.out_count), 64'd10);
      chk("stream_sat_flag",  64'(bus.sat_flag),  64'd1);
    end

    // Reset with two samples in flight, then confirm nothing stale emerges.
    bus.out_ready = 1'b0;
    present(2'd3, 32'h0, 32'h0000_1111, 32'h0);
    wait_accept("flight_a");
    present(2'd3, 32'h0, 32'h0000_2222, 32'h0);
    wait_accept("flight_b");
    bus.in_valid = 1'b0;
    chk("flight_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_count", 64'(bus.out_count), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_result", 64'(bus.out_valid), 64'd0);
    lit_test("post_rst", 2'd3, 32'h0000_0000, 32'h00C0_FFEE, 32'h0000_0000, 32'h00C0_FFEE);

    // Counter wrap after 65535 handshakes.
    do_reset();
    bus.out_ready = 1'b1;
    present(2'd3, 32'h0, 32'h0000_0055, 32'h0);
    begin
      int hs  = 0;
      int cyc = 0;
      while (hs < 65535 && cyc < 70000) begin
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) hs++;
        cyc++;
      end
      @(posedge clk); #1;
      chk("count_ffff", 64'(bus.out_count), 64'h0000_FFFF);
      @(posedge clk); #1;
      chk("count_wrap", 64'(bus.out_count), 64'h0000_0000);
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/act_grad_pipe.md
ACT_GRAD_PIPE -- requirements
Module: act_grad_pipe

Interface
REQ-001 SHALL have parameter FRAC, default 16, meaning fraction bits of the signed 32-bit fixed-point format (1.0 = 1<<FRAC).
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream sample valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-006 SHALL have port in_mode  input  2  0=leaky-ReLU, 1=sigmoid, 2=tanh, 3=pass-through.
REQ-007 SHALL have port in_x  input  32 signed  pre-activation value x saved from the forward pass.
REQ-008 SHALL have port in_grad  input  32 signed  upstream gradient dL/dy.
REQ-009 SHALL have port leak_a  input  32 signed  leaky slope, captured with each accepted sample.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_grad  output  32 signed  dL/dx = in_grad * f'(x).
REQ-013 SHALL have port sat_flag  output  1  sticky; set when any result saturated.
REQ-014 SHALL have port out_count  output  16  number of results consumed, wrapping.

Function
REQ-015 SHALL accept a sample when in_valid && in_ready, and transfer a result when out_valid && out_ready.
REQ-016 SHALL be a 2-stage pipeline: S1 registers the operands and the segment/shift code; S2 (the output register) holds the product. Latency is 2 cycles from acceptance to out_valid with no stall.
REQ-017 SHALL assert in_ready = !S1_valid || !S2_valid || out_ready, which gives one sample per cycle at full throughput.
REQ-018 SHALL hold out_grad and out_valid stable while out_valid && !out_ready, and SHALL neither drop nor duplicate any sample.
REQ-019 Leaky-ReLU, x>0: result = in_grad; otherwise result = (leak_a*in_grad)>>>FRAC, using a 64-bit signed product saturated to 32 bits.
REQ-020 Sigmoid slope by |x|:
- below 1.0: grad>>>2
- [1.0,2.0): grad>>>3
- [2.0,4.0): grad>>>5
- >=4.0: 0
REQ-021 Tanh slope by |x|:
- below 0.5: grad
- [0.5,1.0): grad>>>1
- [1.0,2.0): grad>>>2
- [2.0,3.0): grad>>>4
- >=3.0: 0
REQ-022 SHALL compute |x| for segment selection without overflow; x = -2^31 falls in the outermost segment.
REQ-023 All shifts SHALL be arithmetic and truncate toward negative infinity.
REQ-024 Mode 3 SHALL pass in_grad through unchanged.
REQ-025 Saturation SHALL clamp to 0x7FFFFFFF or 0x80000000 and set sat_flag in the same cycle the result enters S2. sat_flag clears only on reset.
REQ-026 out_count SHALL increment once per output handshake and wrap 0xFFFF -> 0x0000.
REQ-027 SHALL hold S1 when S2 is stalled. Simultaneous accept and output transfer in one cycle is legal, and every stage SHALL advance in that cycle.
REQ-028 Segment boundaries SHALL use the lower-inclusive rule: a value exactly equal to a breakpoint belongs to the upper segment.

Reset
REQ-029 While rst_n=0, out_valid, S1_valid, out_grad, sat_flag and out_count SHALL be 0, and in_ready SHALL be 1.
REQ-030 Reset mid-operation SHALL discard every in-flight sample. The first sample accepted after release SHALL appear 2 cycles later.
REQ-031 Deassertion of rst_n SHALL be synchronised internally so that no partial stage update occurs on the release edge.

Verification
REQ-032 Sigmoid, x=0x00008000 (0.5), grad=0x00010000 -> out_grad=0x00004000 two cycles after acceptance.
REQ-033 Tanh, x=0xFFFE8000 (-1.5), grad=0x00040000 -> out_grad=0x00010000. Tanh, x=0x00030000 -> out_grad=0.
REQ-034 Leaky-ReLU, x=-1, grad=0x7FFFFFFF, leak_a=0x00030000 -> out_grad=0x7FFFFFFF and sat_flag=1. x=0 with leak_a=0x00001999 SHALL select the negative branch.
REQ-035 Stream 10 back-to-back samples with out_ready toggling randomly -> 10 results in order, none lost or duplicated, and out_count=10.
REQ-036 Assert rst_n=0 with two samples in flight -> out_valid=0 immediately and out_count=0; no stale result appears after release.
REQ-037 Preload out_count=0xFFFF via 65535 handshakes, then one more handshake -> out_count=0x0000.
